wb_stage: RTL and testbench

- Writeback stage of the pipeline, directly upstream of the general-purpose register file.
- Accepts retiring instructions from the execute/memory stage and waits for load data where needed.
- For loads, aligns and sign/zero-extends the byte or halfword, then drives the register file write port (we/rd/di) for exactly one cycle.
- Also publishes the pending destination register for hazard interlock and keeps an instructions-retired counter.

---
 rtl/wb_stage.sv | 140 ++++++++++++++
 tb/tb_wb_stage.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// Writeback stage: retires ALU/LINK results directly and waits for load data,
// then extracts/extends it and drives the register-file write port for one cycle.
module wb_stage #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_kind,
    input  logic [4:0]       in_rd,
    input  logic [31:0]      in_alu,
    input  logic [31:0]      in_pc4,
    input  logic [2:0]       in_funct3,
    input  logic [1:0]       in_addr_lo,
    input  logic             mem_rvalid,
    input  logic [31:0]      mem_rdata,
    output logic             gpr_we,
    output logic [4:0]       gpr_rd,
    output logic [31:0]      gpr_di,
    output logic             pend_valid,
    output logic [4:0]       pend_rd,
    output logic             exc_misalign,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [1:0] {IDLE, WAIT_MEM, WRITE} state_t;
    typedef enum logic [1:0] {K_NONE, K_ALU, K_LOAD, K_LINK} kind_t;

    state_t      state, nxt_state;
    logic [4:0]  ld_rd;
    logic [2:0]  ld_funct3;
    logic [1:0]  ld_addr_lo;
    logic        accept;
    logic        is_load;
    logic        ld_bad;
    logic        writes;

    function automatic logic [31:0] load_data(input logic [2:0]  f3,
                                              input logic [1:0]  lo,
                                              input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(w >> {lo, 3'b000});
        h = lo[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'b0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'b0, h};
            default: return w;
        endcase
    endfunction

    assign in_ready = (state == IDLE) || (state == WRITE);
    assign accept   = in_valid && in_ready;
    assign is_load  = (in_kind == K_LOAD);
    assign writes   = (in_kind != K_NONE) && (in_rd != 5'd0);

    // Illegal widths (011, 11x) are rejected the same way as misaligned accesses.
    always_comb begin
        ld_bad = 1'b0;
        case (in_funct3)
            3'b000, 3'b100: ld_bad = 1'b0;
            3'b001, 3'b101: ld_bad = in_addr_lo[0];
            3'b010:         ld_bad = (in_addr_lo != 2'b00);
            default:        ld_bad = 1'b1;
        endcase
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        nxt_state = state;
        case (state)
            IDLE, WRITE: begin
                if (!accept)      nxt_state = IDLE;
                else if (!is_load) nxt_state = WRITE;
                else if (ld_bad)   nxt_state = IDLE;
                else               nxt_state = WAIT_MEM;
            end
            WAIT_MEM: if (mem_rvalid) nxt_state = WRITE;
            default:  nxt_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt_state;
    end

    // NOTE: every register, including the latched load context, is cleared by the async reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gpr_we       <= 1'b0;
            gpr_rd       <= 5'd0;
            gpr_di       <= 32'd0;
            pend_valid   <= 1'b0;
            pend_rd      <= 5'd0;
            exc_misalign <= 1'b0;
            retired      <= '0;
            ld_rd        <= 5'd0;
            ld_funct3    <= 3'd0;
            ld_addr_lo   <= 2'd0;
        end else begin
            gpr_we       <= 1'b0;
            exc_misalign <= 1'b0;
            if (nxt_state == WRITE) retired <= retired + CNT_W'(1);

            if (accept) begin
                if (is_load) begin
                    exc_misalign <= ld_bad;
                    pend_valid   <= !ld_bad && (in_rd != 5'd0);
                    pend_rd      <= (!ld_bad && in_rd != 5'd0) ? in_rd : 5'd0;
                    ld_rd        <= in_rd;
                    ld_funct3    <= in_funct3;
                    ld_addr_lo   <= in_addr_lo;
                end else begin
                    gpr_we     <= writes;
                    pend_valid <= writes;
                    pend_rd    <= writes ? in_rd : 5'd0;
                    if (in_kind != K_NONE) begin
                        gpr_rd <= in_rd;
                        gpr_di <= (in_kind == K_LINK) ? in_pc4 : in_alu;
                    end
                end
            end else if (state == WAIT_MEM) begin
                if (mem_rvalid) begin
                    gpr_we <= (ld_rd != 5'd0);
                    gpr_rd <= ld_rd;
                    gpr_di <= load_data(ld_funct3, ld_addr_lo, mem_rdata);
                end
            end else begin
                pend_valid <= 1'b0;
                pend_rd    <= 5'd0;
            end
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage; a second instance with a 3-bit counter checks wrap.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [1:0]  in_kind;
    logic [4:0]  in_rd;
    logic [31:0] in_alu, in_pc4;
    logic [2:0]  in_funct3;
    logic [1:0]  in_addr_lo;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    logic        in_ready, gpr_we, pend_valid, exc_misalign;
    logic [4:0]  gpr_rd, pend_rd;
    logic [31:0] gpr_di, retired;

    logic        in_ready_s, gpr_we_s, pend_valid_s, exc_misalign_s;
    logic [4:0]  gpr_rd_s, pend_rd_s;
    logic [31:0] gpr_di_s;
    logic [2:0]  retired_s;

    int checks   = 0;
    int failures = 0;
    int exp_ret  = 0;

    always #5 clk = ~clk;

    wb_stage #(.CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_kind(in_kind), .in_rd(in_rd), .in_alu(in_alu), .in_pc4(in_pc4),
        .in_funct3(in_funct3), .in_addr_lo(in_addr_lo), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .gpr_we(gpr_we), .gpr_rd(gpr_rd), .gpr_di(gpr_di),
        .pend_valid(pend_valid), .pend_rd(pend_rd), .exc_misalign(exc_misalign),
        .retired(retired)
    );

    wb_stage #(.CNT_W(3)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_kind(in_kind), .in_rd(in_rd), .in_alu(in_alu), .in_pc4(in_pc4),
        .in_funct3(in_funct3), .in_addr_lo(in_addr_lo), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .gpr_we(gpr_we_s), .gpr_rd(gpr_rd_s), .gpr_di(gpr_di_s),
        .pend_valid(pend_valid_s), .pend_rd(pend_rd_s), .exc_misalign(exc_misalign_s),
        .retired(retired_s)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; in_kind = 2'd0; in_rd = 5'd0; in_alu = 32'd0; in_pc4 = 32'd0;
        in_funct3 = 3'd0; in_addr_lo = 2'd0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
    endtask

    task automatic present(input logic [1:0] kind, input logic [4:0] rd,
                           input logic [31:0] alu, input logic [31:0] pc4,
                           input logic [2:0] f3, input logic [1:0] lo);
        in_valid = 1'b1; in_kind = kind; in_rd = rd; in_alu = alu; in_pc4 = pc4;
        in_funct3 = f3; in_addr_lo = lo;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #12;
        checks++;
        if ({gpr_we, gpr_rd, gpr_di, pend_valid, pend_rd, exc_misalign} !== 45'd0 || retired !== 32'd0) begin
            failures++;
            $display("FAIL reset_outputs: we=%b rd=%0d di=%h pv=%b prd=%0d exc=%b ret=%0d, required all zero",
                     gpr_we, gpr_rd, gpr_di, pend_valid, pend_rd, exc_misalign, retired);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1) begin
            failures++; $display("FAIL reset_ready: in_ready=%b required 1", in_ready);
        end
        exp_ret = 0;
    endtask

    task automatic test_alu();
        present(2'd1, 5'd5, 32'h1234_5678, 32'h0, 3'd0, 2'd0);
        tick();
        in_valid = 1'b0;
        exp_ret++;
        checks++;
        if (gpr_we !== 1'b1 || gpr_rd !== 5'd5 || gpr_di !== 32'h1234_5678 || retired !== 32'(exp_ret)) begin
            failures++;
            $display("FAIL alu_write: we=%b rd=%0d di=%h ret=%0d, required 1/5/12345678/%0d",
                     gpr_we, gpr_rd, gpr_di, retired, exp_ret);
        end
        checks++;
        if (pend_valid !== 1'b1 || pend_rd !== 5'd5) begin
            failures++; $display("FAIL alu_pend: pv=%b prd=%0d required 1/5", pend_valid, pend_rd);
        end
        tick();
        checks++;
        if (gpr_we !== 1'b0 || pend_valid !== 1'b0 || gpr_di !== 32'h1234_5678 || retired !== 32'(exp_ret)) begin
            failures++;
            $display("FAIL alu_after: we=%b pv=%b di=%h ret=%0d, required 0/0/12345678/%0d",
                     gpr_we, pend_valid, gpr_di, retired, exp_ret);
        end
    endtask

    task automatic do_load(input string name, input logic [2:0] f3, input logic [1:0] lo,
                           input logic [4:0] rd, input logic [31:0] data, input logic [31:0] exp_di);
        present(2'd2, rd, 32'hDEAD_DEAD, 32'h0, f3, lo);
        tick();
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0 || gpr_we !== 1'b0 || pend_valid !== 1'b1 || pend_rd !== rd) begin
            failures++;
            $display("FAIL %s_wait: ready=%b we=%b pv=%b prd=%0d, required 0/0/1/%0d",
                     name, in_ready, gpr_we, pend_valid, pend_rd, rd);
        end
        tick();
        checks++;
        if (in_ready !== 1'b0 || gpr_we !== 1'b0) begin
            failures++; $display("FAIL %s_wait2: ready=%b we=%b required 0/0", name, in_ready, gpr_we);
        end
        mem_rvalid = 1'b1; mem_rdata = data;
        tick();
        mem_rvalid = 1'b0; mem_rdata = 32'h5555_5555;
        exp_ret++;
        checks++;
        if (gpr_we !== 1'b1 || gpr_rd !== rd || gpr_di !== exp_di || retired !== 32'(exp_ret) || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s_write: we=%b rd=%0d di=%h ret=%0d ready=%b, required 1/%0d/%h/%0d/1",
                     name, gpr_we, gpr_rd, gpr_di, retired, in_ready, rd, exp_di, exp_ret);
        end
        tick();
        checks++;
        if (gpr_we !== 1'b0 || pend_valid !== 1'b0) begin
            failures++; $display("FAIL %s_done: we=%b pv=%b required 0/0", name, gpr_we, pend_valid);
        end
    endtask

    task automatic test_loads();
        do_load("lb",  3'b000, 2'd3, 5'd7,  32'h80FF_0000, 32'hFFFF_FF80);
        do_load("lhu", 3'b101, 2'd2, 5'd8,  32'hBEEF_0001, 32'h0000_BEEF);
        do_load("lh",  3'b001, 2'd2, 5'd9,  32'hBEEF_0001, 32'hFFFF_BEEF);
        do_load("lbu", 3'b100, 2'd1, 5'd10, 32'h1234_80AB, 32'h0000_0080);
        do_load("lh0", 3'b001, 2'd0, 5'd11, 32'h1234_8001, 32'hFFFF_8001);
        do_load("lw",  3'b010, 2'd0, 5'd12, 32'hCAFE_F00D, 32'hCAFE_F00D);
    endtask

    task automatic do_bad_load(input string name, input logic [2:0] f3, input logic [1:0] lo);
        present(2'd2, 5'd6, 32'h0, 32'h0, f3, lo);
        tick();
        in_valid = 1'b0;
        checks++;
        if (exc_misalign !== 1'b1 || gpr_we !== 1'b0 || in_ready !== 1'b1 || pend_valid !== 1'b0 ||
            retired !== 32'(exp_ret)) begin
            failures++;
            $display("FAIL %s_exc: exc=%b we=%b ready=%b pv=%b ret=%0d, required 1/0/1/0/%0d",
                     name, exc_misalign, gpr_we, in_ready, pend_valid, retired, exp_ret);
        end
        tick();
        checks++;
        if (exc_misalign !== 1'b0 || gpr_we !== 1'b0 || retired !== 32'(exp_ret)) begin
            failures++;
            $display("FAIL %s_after: exc=%b we=%b ret=%0d, required 0/0/%0d",
                     name, exc_misalign, gpr_we, retired, exp_ret);
        end
    endtask

    task automatic test_misalign();
        do_bad_load("lw_lo1",  3'b010, 2'd1);
        do_bad_load("lhu_lo3", 3'b101, 2'd3);
        do_bad_load("illegal", 3'b011, 2'd0);
    endtask

    task automatic test_stray_rvalid();
        mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        tick();
        mem_rvalid = 1'b0;
        checks++;
        if (gpr_we !== 1'b0 || retired !== 32'(exp_ret) || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL stray_rvalid: we=%b ret=%0d ready=%b, required 0/%0d/1",
                     gpr_we, retired, in_ready, exp_ret);
        end
    endtask

    task automatic test_none();
        present(2'd0, 5'd4, 32'h7777_7777, 32'h0, 3'd0, 2'd0);
        tick();
        in_valid = 1'b0;
        exp_ret++;
        checks++;
        if (gpr_we !== 1'b0 || pend_valid !== 1'b0 || retired !== 32'(exp_ret)) begin
            failures++;
            $display("FAIL none_kind: we=%b pv=%b ret=%0d, required 0/0/%0d",
                     gpr_we, pend_valid, retired, exp_ret);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        present(2'd1, 5'd1, 32'h0000_000A, 32'h0, 3'd0, 2'd0);
        tick();
        exp_ret++;
        checks++;
        if (gpr_we !== 1'b1 || gpr_rd !== 5'd1 || gpr_di !== 32'hA || pend_rd !== 5'd1) begin
            failures++;
            $display("FAIL b2b_first: we=%b rd=%0d di=%h prd=%0d, required 1/1/a/1",
                     gpr_we, gpr_rd, gpr_di, pend_rd);
        end
        present(2'd3, 5'd0, 32'h0, 32'h0000_0100, 3'd0, 2'd0);
        tick();
        exp_ret++;
        checks++;
        if (gpr_we !== 1'b0 || pend_valid !== 1'b0 || pend_rd !== 5'd0) begin
            failures++;
            $display("FAIL b2b_link_rd0: we=%b pv=%b prd=%0d, required 0/0/0", gpr_we, pend_valid, pend_rd);
        end
        present(2'd1, 5'd2, 32'h0000_000B, 32'h0, 3'd0, 2'd0);
        tick();
        in_valid = 1'b0;
        exp_ret++;
        checks++;
        if (gpr_we !== 1'b1 || gpr_rd !== 5'd2 || gpr_di !== 32'hB || pend_rd !== 5'd2 ||
            retired !== 32'(exp_ret)) begin
            failures++;
            $display("FAIL b2b_third: we=%b rd=%0d di=%h prd=%0d ret=%0d, required 1/2/b/2/%0d",
                     gpr_we, gpr_rd, gpr_di, pend_rd, retired, exp_ret);
        end
        tick();
    endtask

    task automatic test_reset_mid_load();
        present(2'd2, 5'd13, 32'h0, 32'h0, 3'b010, 2'd0);
        tick();
        in_valid = 1'b0;
        rst_n = 1'b0;
        #2;
        checks++;
        if (in_ready !== 1'b1 || pend_valid !== 1'b0 || retired !== 32'd0) begin
            failures++;
            $display("FAIL async_reset: ready=%b pv=%b ret=%0d, required 1/0/0", in_ready, pend_valid, retired);
        end
        rst_n = 1'b1;
        exp_ret = 0;
        @(negedge clk);
        mem_rvalid = 1'b1; mem_rdata = 32'h1111_1111;
        tick();
        mem_rvalid = 1'b0;
        checks++;
        if (gpr_we !== 1'b0 || in_ready !== 1'b1 || retired !== 32'd0) begin
            failures++;
            $display("FAIL reset_drop_load: we=%b ready=%b ret=%0d, required 0/1/0", gpr_we, in_ready, retired);
        end
    endtask

    task automatic test_wrap();
        present(2'd1, 5'd3, 32'h0, 32'h0, 3'd0, 2'd0);
        for (int i = 0; i < 8; i++) begin
            in_alu = 32'(i);
            tick();
            exp_ret++;
            checks++;
            if (retired_s !== 3'(exp_ret) || gpr_we !== 1'b1 || gpr_di !== 32'(i)) begin
                failures++;
                $display("FAIL wrap_step%0d: small_ret=%0d we=%b di=%h, required %0d/1/%h",
                         i, retired_s, gpr_we, gpr_di, 3'(exp_ret), 32'(i));
            end
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (retired_s !== 3'd0 || retired !== 32'd8) begin
            failures++;
            $display("FAIL wrap_final: small_ret=%0d ret=%0d, required 0/8", retired_s, retired);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_loads();
        test_misalign();
        test_stray_rvalid();
        test_none();
        test_back_to_back();
        test_reset_mid_load();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
